conv_stream_ctrl: RTL and testbench

// Host-side sequencer for the convolution core. Three phases:
// - Stream X and Y samples into the core's input memories.
// - Pulse the core's start, then wait for its done.
// - Read the Z result memory written by the core, and stream it out over valid/ready with a last flag.

---
 rtl/conv_pkg.sv | 12 +
 rtl/z_skid_buf.sv | 34 +++
 rtl/conv_stream_ctrl.sv | 109 ++++++++++
 tb/tb_conv_stream_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// conv_pkg: shared FSM encoding, default widths and Z length sizing for the convolution stream controller
package conv_pkg;
  typedef enum logic [2:0] {IDLE, LOAD_X, LOAD_Y, START, WAIT, READ, DRAIN} state_t;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_ZDATA_W = 16;
  localparam int DEF_ZADDR_W = 6;
  // Z length can equal 2**ZADDR_W - 1 plus a full count, so it needs one extra bit
  function automatic int zlenW(input int zaddrW);
    return zaddrW + 1;
  endfunction
endpackage

// File: rtl/z_skid_buf.sv
// z_skid_buf: 2-entry FIFO with registered head, flush, and writes only on valid input
module z_skid_buf #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         flush,
  input  logic         inValid,
  input  logic [W-1:0] inData,
  input  logic         outReady,
  output logic         outValid,
  output logic [W-1:0] outData,
  output logic [1:0]   count
);
  logic [W-1:0] tail;
  logic push, pop;
  assign outValid = count != 2'd0;
  assign pop = outValid && outReady;
  assign push = inValid && (count != 2'd2 || pop);
  // Head always holds the oldest entry; tail only fills when the head is occupied
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      count <= 2'd0;
      outData <= '0;
      tail <= '0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      count <= count + {1'b0, push} - {1'b0, pop};
      if (push && (count == 2'd0 || (count == 2'd1 && pop))) outData <= inData;
      else if (pop && count == 2'd2) outData <= tail;
      if (push && ((count == 2'd1 && !pop) || (count == 2'd2 && pop))) tail <= inData;
    end
endmodule

// File: rtl/conv_stream_ctrl.sv
// conv_stream_ctrl: loads X/Y samples, kicks the convolution core, then streams Z results out
module conv_stream_ctrl import conv_pkg::*; #(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int ZDATA_W = DEF_ZDATA_W,
  parameter int ZADDR_W = DEF_ZADDR_W
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               go_i,
  input  logic [ADDR_W:0]    sizeX_i,
  input  logic [ADDR_W:0]    sizeY_i,
  input  logic               s_valid_i,
  input  logic [DATA_W-1:0]  s_data_i,
  output logic               s_ready_o,
  output logic               memX_we_o,
  output logic               memY_we_o,
  output logic [ADDR_W-1:0]  mem_addr_o,
  output logic [DATA_W-1:0]  mem_data_o,
  output logic               conv_start_o,
  input  logic               conv_done_i,
  output logic [ZADDR_W-1:0] memZ_addr_o,
  input  logic [ZDATA_W-1:0] memZ_data_i,
  output logic               m_valid_o,
  output logic [ZDATA_W-1:0] m_data_o,
  output logic               m_last_o,
  input  logic               m_ready_i,
  output logic               busy_o,
  output logic               err_o
);
  localparam int ZLW = zlenW(ZADDR_W);
  localparam logic [ADDR_W:0] MAXN = (ADDR_W+1)'(2**ADDR_W);
  state_t state, stateNext;
  logic [ADDR_W:0] sizeX, sizeY;
  logic [ADDR_W-1:0] cnt;
  logic [ZLW-1:0] zlen;
  logic [ZADDR_W-1:0] zcnt;
  logic [ZDATA_W:0] skidOut;
  logic [1:0] occ;
  logic rdPend, rdLast, hs, loadLast, goBad, issue, zLastAddr, pop;
  assign s_ready_o = state == LOAD_X || state == LOAD_Y;
  assign hs = s_valid_i && s_ready_o;
  assign memX_we_o = hs && state == LOAD_X;
  assign memY_we_o = hs && state == LOAD_Y;
  assign mem_addr_o = cnt;
  assign mem_data_o = s_ready_o ? s_data_i : '0;
  assign loadLast = {1'b0, cnt} == (state == LOAD_Y ? sizeY : sizeX) - (ADDR_W+1)'(1);
  assign goBad = sizeX_i == '0 || sizeY_i == '0 || sizeX_i > MAXN || sizeY_i > MAXN;
  assign zLastAddr = ZLW'(zcnt) == zlen - ZLW'(1);
  assign pop = m_valid_o && m_ready_i;
  assign issue = state == READ && ({1'b0, occ} + {2'b0, rdPend}) < (3'd2 + {2'b0, pop});
  assign memZ_addr_o = zcnt;
  assign m_data_o = skidOut[ZDATA_W-1:0];
  assign m_last_o = m_valid_o && skidOut[ZDATA_W];
  // State, job parameters, load/read counters and the one-cycle read pipeline tag
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state <= IDLE;
      sizeX <= '0;
      sizeY <= '0;
      cnt <= '0;
      zlen <= '0;
      zcnt <= '0;
      rdPend <= 1'b0;
      rdLast <= 1'b0;
      err_o <= 1'b0;
    end else begin
      state <= stateNext;
      rdPend <= issue;
      rdLast <= issue && zLastAddr;
      if (state == IDLE && go_i) begin
        err_o <= goBad;
        if (!goBad) begin
          sizeX <= sizeX_i;
          sizeY <= sizeY_i;
        end
      end
      if (hs) cnt <= loadLast ? '0 : cnt + ADDR_W'(1);
      if (state == WAIT && conv_done_i) zlen <= ZLW'(sizeX) + ZLW'(sizeY) - ZLW'(1);
      if (issue) zcnt <= zLastAddr ? '0 : zcnt + ZADDR_W'(1);
    end
  // Next-state sequencing and the start pulse
  always_comb begin
    stateNext = state;
    conv_start_o = 1'b0;
    busy_o = state != IDLE;
    case (state)
      IDLE:    if (go_i && !goBad) stateNext = LOAD_X;
      LOAD_X:  if (hs && loadLast) stateNext = LOAD_Y;
      LOAD_Y:  if (hs && loadLast) stateNext = START;
      START:   begin conv_start_o = 1'b1; stateNext = WAIT; end
      WAIT:    if (conv_done_i) stateNext = READ;
      READ:    if (issue && zLastAddr) stateNext = DRAIN;
      DRAIN:   if (pop && m_last_o) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end
  z_skid_buf #(.W(ZDATA_W + 1)) uSkid (
    .clk(clk),
    .rstn(rstn),
    .flush(state == IDLE),
    .inValid(rdPend),
    .inData({rdLast, memZ_data_i}),
    .outReady(m_ready_i),
    .outValid(m_valid_o),
    .outData(skidOut),
    .count(occ)
  );
endmodule

// File: tb/tb_conv_stream_ctrl.sv
// tb_conv_stream_ctrl: randomized jobs against a convolution reference model and a behavioural core
module tb_conv_stream_ctrl;
  logic clk = 1'b0;
  logic rstn, go_i, s_valid_i, conv_done_i, m_ready_i;
  logic [5:0] sizeX_i, sizeY_i;
  logic [7:0] s_data_i, mem_data_o;
  logic s_ready_o, memX_we_o, memY_we_o, conv_start_o, m_valid_o, m_last_o, busy_o, err_o;
  logic [4:0] mem_addr_o;
  logic [5:0] memZ_addr_o;
  logic [15:0] memZ_data_i, m_data_o;
  logic [7:0] memX [32];
  logic [7:0] memY [32];
  logic [15:0] memZ [64];
  logic [7:0] jobX [32];
  logic [7:0] jobY [32];
  int wrX [32];
  int wrY [32];
  logic [15:0] gotD [$];
  bit gotL [$];
  logic [15:0] stallData;
  bit stallPrev = 1'b0, spurReq = 1'b0;
  int cyc = 0, doneCnt = 0, doneCyc = 0, startCnt = 0, curX = 1, curY = 1;
  int firstValidCyc = -1, firstBeatCyc = -1, lastBeatCyc = -1;
  int nChecks = 0, nFails = 0;

  always #5 clk = ~clk;

  conv_stream_ctrl dut (
    .clk(clk), .rstn(rstn), .go_i(go_i), .sizeX_i(sizeX_i), .sizeY_i(sizeY_i),
    .s_valid_i(s_valid_i), .s_data_i(s_data_i), .s_ready_o(s_ready_o),
    .memX_we_o(memX_we_o), .memY_we_o(memY_we_o), .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .conv_start_o(conv_start_o), .conv_done_i(conv_done_i),
    .memZ_addr_o(memZ_addr_o), .memZ_data_i(memZ_data_i),
    .m_valid_o(m_valid_o), .m_data_o(m_data_o), .m_last_o(m_last_o), .m_ready_i(m_ready_i),
    .busy_o(busy_o), .err_o(err_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Z memory with one cycle read latency
  always @(posedge clk) memZ_data_i <= memZ[memZ_addr_o];

  // Mid-cycle monitor: X/Y memories, output beats, stall stability, and the behavioural core
  always @(negedge clk) begin
    cyc++;
    if (!rstn) begin
      doneCnt = 0;
      conv_done_i = 1'b0;
      stallPrev = 1'b0;
    end else begin
      if (memX_we_o) begin memX[mem_addr_o] = mem_data_o; wrX[mem_addr_o]++; end
      if (memY_we_o) begin memY[mem_addr_o] = mem_data_o; wrY[mem_addr_o]++; end
      if (stallPrev) begin
        check("stall_valid", m_valid_o, 1);
        check("stall_data", m_data_o, stallData);
      end
      stallPrev = m_valid_o && !m_ready_i;
      stallData = m_data_o;
      if (m_valid_o && firstValidCyc < 0) firstValidCyc = cyc;
      if (m_valid_o && m_ready_i) begin
        gotD.push_back(m_data_o);
        gotL.push_back(m_last_o);
        if (firstBeatCyc < 0) firstBeatCyc = cyc;
        lastBeatCyc = cyc;
      end
      conv_done_i = spurReq;
      if (doneCnt > 0) begin
        doneCnt--;
        if (doneCnt == 0) begin conv_done_i = 1'b1; doneCyc = cyc; end
      end
      if (conv_start_o) begin
        startCnt++;
        firstValidCyc = -1;
        firstBeatCyc = -1;
        for (int k = 0; k < curX + curY - 1; k++) begin
          memZ[k] = '0;
          for (int i = 0; i < curX; i++)
            if (k - i >= 0 && k - i < curY) memZ[k] = memZ[k] + memX[i] * memY[k - i];
        end
        doneCnt = $urandom_range(1, 4);
      end
    end
  end

  task automatic runJob(input int sx, input int sy, input int mode, input bit spur, input int abortAt);
    logic [15:0] expZ [64];
    int wxb [32];
    int wyb [32];
    logic [5:0] pat;
    int zl, gb, sb, idx, guard;
    bit acc;
    pat = 6'b101001;
    zl = sx + sy - 1;
    for (int k = 0; k < zl; k++) begin
      expZ[k] = '0;
      for (int i = 0; i < sx; i++)
        if (k - i >= 0 && k - i < sy) expZ[k] = expZ[k] + jobX[i] * jobY[k - i];
    end
    curX = sx; curY = sy; gb = gotD.size(); sb = startCnt; wxb = wrX; wyb = wrY;
    go_i = 1'b1; sizeX_i = 6'(sx); sizeY_i = 6'(sy); m_ready_i = 1'b0;
    @(posedge clk); #2;
    go_i = 1'b0; sizeX_i = 6'($urandom); sizeY_i = 6'($urandom);
    check("busy_after_go", busy_o, 1);
    check("err_after_go", err_o, 0);
    idx = 0; guard = 0;
    while (idx < sx + sy && guard < 2000) begin
      s_valid_i = $urandom_range(0, 2) != 0;
      s_data_i = idx < sx ? jobX[idx] : jobY[idx - sx];
      go_i = spur && idx == 1;
      spurReq = spur && idx == 1;
      @(negedge clk);
      acc = s_valid_i && s_ready_o;
      @(posedge clk); #2;
      if (acc) idx++;
      guard++;
    end
    s_valid_i = 1'b0; go_i = 1'b0; spurReq = 1'b0;
    check("samples_accepted", idx, sx + sy);
    guard = 0;
    while (gotD.size() - gb < zl && guard < 1000) begin
      if (abortAt > 0 && gotD.size() - gb >= abortAt) break;
      m_ready_i = mode == 0 ? 1'b1 : mode == 1 ? pat[guard % 6] : 1'($urandom_range(0, 1));
      @(posedge clk); #2;
      guard++;
    end
    if (abortAt > 0) begin
      check("abort_beats", gotD.size() - gb, abortAt);
      rstn = 1'b0;
      #1;
      check("rst_valid", m_valid_o, 0);
      check("rst_last", m_last_o, 0);
      check("rst_data", m_data_o, 0);
      check("rst_busy", busy_o, 0);
      check("rst_ready", s_ready_o, 0);
      check("rst_start", conv_start_o, 0);
      check("rst_we", {memX_we_o, memY_we_o}, 0);
      check("rst_zaddr", memZ_addr_o, 0);
      check("rst_err", err_o, 0);
      repeat (2) @(posedge clk);
      #2 rstn = 1'b1; m_ready_i = 1'b0;
      @(posedge clk); #2;
      return;
    end
    check("beat_count", gotD.size() - gb, zl);
    check("busy_drop", busy_o, 0);
    for (int k = 0; k < zl; k++)
      if (gb + k < gotD.size()) begin
        check("z_data", gotD[gb + k], expZ[k]);
        check("z_last", gotL[gb + k], k == zl - 1);
      end
    check("start_pulses", startCnt - sb, 1);
    for (int i = 0; i < 32; i++) begin
      check("memx_writes", wrX[i] - wxb[i], i < sx);
      check("memy_writes", wrY[i] - wyb[i], i < sy);
    end
    check("first_valid_latency", firstValidCyc - doneCyc, 3);
    if (mode == 0) check("no_bubble", lastBeatCyc - firstBeatCyc, zl - 1);
    repeat (3) @(posedge clk);
    #2;
    check("no_extra_beats", gotD.size() - gb, zl);
  endtask

  task automatic badGo(input int sx, input int sy);
    go_i = 1'b1; sizeX_i = 6'(sx); sizeY_i = 6'(sy);
    @(posedge clk); #2;
    go_i = 1'b0;
    check("err_set", err_o, 1);
    check("err_idle", busy_o, 0);
    check("err_no_ready", s_ready_o, 0);
    @(posedge clk); #2;
    check("err_sticky", err_o, 1);
  endtask

  task automatic fillRandom(input int sx, input int sy);
    for (int i = 0; i < sx; i++) jobX[i] = 8'($urandom);
    for (int i = 0; i < sy; i++) jobY[i] = 8'($urandom);
  endtask

  task automatic fillDirected();
    for (int i = 0; i < 4; i++) jobX[i] = 8'(i + 1);
    for (int i = 0; i < 3; i++) jobY[i] = 8'd1;
  endtask

  initial begin
    rstn = 1'b0; go_i = 1'b0; s_valid_i = 1'b0; m_ready_i = 1'b0;
    sizeX_i = '0; sizeY_i = '0; s_data_i = '0;
    repeat (3) @(posedge clk);
    #2;
    check("reset_busy", busy_o, 0);
    check("reset_valid", m_valid_o, 0);
    check("reset_err", err_o, 0);
    check("reset_start", conv_start_o, 0);
    check("reset_ready", s_ready_o, 0);
    rstn = 1'b1;
    @(posedge clk); #2;
    fillDirected();
    runJob(4, 3, 0, 1'b0, 0);
    runJob(4, 3, 1, 1'b0, 0);
    badGo(0, 3);
    badGo(3, 33);
    runJob(4, 3, 2, 1'b0, 0);
    fillRandom(5, 4);
    runJob(5, 4, 2, 1'b1, 0);
    fillRandom(32, 32);
    runJob(32, 32, 0, 1'b0, 0);
    for (int n = 0; n < 6; n++) begin
      int sx, sy;
      sx = $urandom_range(1, 32);
      sy = $urandom_range(1, 32);
      fillRandom(sx, sy);
      runJob(sx, sy, $urandom_range(0, 2), 1'b0, 0);
    end
    fillDirected();
    runJob(4, 3, 0, 1'b0, 2);
    fillRandom(1, 1);
    runJob(1, 1, 0, 1'b0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule
